// File: rtl/bios_mem_arbiter.sv
// bios_mem_arbiter: shares the single-port BIOS memory between the instruction
// fetch port and the load/store data port. Data wins by default; a fetch that
// has been denied MAX_WAIT cycles in a row is forced through. Read data comes
// back one cycle after the grant and is steered by a registered response tag.
module bios_mem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int MAX_WAIT = 4    // legal range 1..15
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,

   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,

   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   // Which requester owns the read data arriving next cycle.
   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_IF   = 2'd1,
      RESP_D    = 2'd2
   } resp_t;

   logic [3:0] wait_cnt;
   resp_t      resp_sel;
   resp_t      resp_next;

   // Grant selection: data has priority unless the fetch has waited its limit.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req && d_req) begin
            if (wait_cnt >= MAX_WAIT_C) begin
               if_gnt = 1'b1;
            end else begin
               d_gnt = 1'b1;
            end
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   // Memory port mux: driven from the granted requester, all zero when idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 4'h0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Starvation counter: counts consecutive denied fetch cycles, saturating.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wait_cnt <= 4'd0;
      end else if (!if_req || if_gnt) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt < MAX_WAIT_C) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Next response tag: a granted fetch or data read expects data next cycle.
   always_comb begin
      resp_next = RESP_NONE;
      if (if_gnt) begin
         resp_next = RESP_IF;
      end else if (d_gnt && (d_we == 4'h0)) begin
         resp_next = RESP_D;
      end
   end

   // Response tag register; reset drops any outstanding read.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_sel <= RESP_NONE;
      end else begin
         resp_sel <= resp_next;
      end
   end

   // A response still in flight when reset arrives is suppressed immediately.
   assign if_rvalid = !rst && (resp_sel == RESP_IF);
   assign d_rvalid  = !rst && (resp_sel == RESP_D);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: doc/bios_mem_arbiter.md
Name: bios_mem_arbiter

Overview:
Shares the single-port synchronous BIOS memory between the CPU instruction-fetch port and the load/store data port. It grants at most one access per cycle and routes the one-cycle-latency read data back to the requester that issued the read. Data accesses have priority over fetches, with a starvation guard so fetch always makes progress. It sits between the riscv core pipeline and bios_mem, replacing their direct connection.

Parameters:
ADDR_W, 12, word-address width (4096 x 32-bit words)
MAX_WAIT, 4, consecutive cycles a fetch may be denied before it is forced to win; legal range 1..15

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
if_req  input  1  fetch read request
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch granted this cycle (combinational)
if_rvalid  output  1  if_rdata valid (registered)
if_rdata  output  32  fetch read data
d_req  input  1  data request
d_we  input  4  byte write enables; 0 means read
d_addr  input  ADDR_W  data word address
d_wdata  input  32  write data
d_gnt  output  1  data granted this cycle (combinational)
d_rvalid  output  1  d_rdata valid (registered)
d_rdata  output  32  data read data
mem_en  output  1  memory access enable
mem_we  output  4  memory byte write enables
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid the cycle after a read access

Behaviour:
- Reset is synchronous, active-high: wait_cnt=0, resp_sel=NONE, if_rvalid=0, d_rvalid=0. While rst=1, if_gnt=d_gnt=mem_en=0 and mem_we=0.
- Grant selection is combinational, same cycle as the request:
  - Only one request asserted: that requester is granted.
  - Both asserted, wait_cnt < MAX_WAIT: data is granted.
  - Both asserted, wait_cnt == MAX_WAIT: fetch is granted.
  - Neither asserted: no grant, mem_en=0.
- The mem_* outputs come from the granted port. A fetch grant drives mem_we=0 and mem_wdata=0. With no grant, mem_addr and mem_wdata hold 0.
- wait_cnt, 4-bit:
  - Increments (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0.
  - Clears to 0 on any cycle with if_gnt=1.
  - Clears to 0 on any cycle with if_req=0.
- resp_sel register, values NONE/IF/D, updated every cycle:
  - IF if the fetch was granted.
  - D if a data read was granted (d_we==0).
  - NONE otherwise; a granted write produces no response.
- Response timing: if_rvalid = (resp_sel==IF) and d_rvalid = (resp_sel==D), both one cycle after the grant. At most one of them is high in any cycle.
- Read data: if_rdata and d_rdata both pass mem_rdata through. Each is meaningful only while its own rvalid is high.
- Read latency is exactly 1 cycle from grant to rvalid. Back-to-back grants are allowed every cycle, so throughput is one access per cycle.
- Requesters hold req/addr/we/wdata stable until granted. An ungranted request is not queued internally.
- Write followed by a read of the same address in the next cycle returns the new data; this relies on memory write-then-read ordering.
- Reset asserted while a read is outstanding: the response is dropped, and rvalid is 0 in the cycle after reset.
- Address wrap: addresses are word indices used as-is, with no range check.

Test Plan:
- Fetch only: if_req=1, if_addr=0..3 over 4 cycles, mem preloaded with 0x00000013 at 0..3 -> if_gnt=1 each cycle; if_rvalid=1 on cycles 1..4 with if_rdata=0x00000013; d_rvalid stays 0.
- Data write then read: d_req=1, d_we=4'hF, d_addr=10, d_wdata=0xDEADBEEF; next cycle d_we=0, d_addr=10 -> no d_rvalid after the write; d_rvalid=1 with d_rdata=0xDEADBEEF one cycle after the read grant.
- Byte write: mem[5]=0x11223344, write d_we=4'b0010 with wdata=0x0000AA00, then read 5 -> 0x1122AA44.
- Contention/starvation, MAX_WAIT=4: if_req and d_req both held high for 12 cycles -> d_gnt on cycles 0..3, if_gnt on cycle 4, d_gnt on 5..8, if_gnt on 9; never both grants in one cycle; each rvalid routed to the matching port.
- Reset mid-read: fetch granted at cycle N, rst=1 at cycle N+1 -> if_rvalid=0 at N+1 and N+2; wait_cnt=0; after rst drops, the first fetch completes normally.
- Idle: no requests for 10 cycles -> mem_en=0 and both rvalid=0 throughout.
